// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter: FSM states and the op code
// reported alongside the current grant.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RD,
    RR
  } state_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10
  } op_t;

  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

endpackage

// File: rtl/axil_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches last_grant+1 upward, wrapping modulo NUM_M,
// and returns the first requester as both a one-hot vector and an index.
module rr_pick #(
  parameter int unsigned NUM_M = 2
) (
  input  logic [NUM_M-1:0]         req,
  input  logic [$clog2(NUM_M)-1:0] last_grant,
  output logic                     any,
  output logic [NUM_M-1:0]         onehot,
  output logic [$clog2(NUM_M)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_M);

  always_comb begin
    int unsigned cand;
    cand   = 0;
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = (32'(last_grant) + k) % NUM_M;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                       = 1'b1;
        onehot[cand[IDX_W-1:0]]   = 1'b1;
        idx                       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Shares one downstream AXI4-Lite port between NUM_M masters, one transaction at a time,
// with round-robin grant chosen in IDLE and the winner's channels muxed through until done.
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUM_M      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // upstream write address
  input  logic [NUM_M*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [NUM_M*PROT_W-1:0]     s_axil_awprot,
  input  logic [NUM_M-1:0]            s_axil_awvalid,
  output logic [NUM_M-1:0]            s_axil_awready,
  // upstream write data
  input  logic [NUM_M*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [NUM_M*STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic [NUM_M-1:0]            s_axil_wvalid,
  output logic [NUM_M-1:0]            s_axil_wready,
  // upstream write response
  output logic [RESP_W-1:0]           s_axil_bresp,
  output logic [NUM_M-1:0]            s_axil_bvalid,
  input  logic [NUM_M-1:0]            s_axil_bready,
  // upstream read address
  input  logic [NUM_M*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [NUM_M*PROT_W-1:0]     s_axil_arprot,
  input  logic [NUM_M-1:0]            s_axil_arvalid,
  output logic [NUM_M-1:0]            s_axil_arready,
  // upstream read data
  output logic [DATA_WIDTH-1:0]       s_axil_rdata,
  output logic [RESP_W-1:0]           s_axil_rresp,
  output logic [NUM_M-1:0]            s_axil_rvalid,
  input  logic [NUM_M-1:0]            s_axil_rready,
  // downstream port
  output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
  output logic [PROT_W-1:0]           m_axil_awprot,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [DATA_WIDTH-1:0]       m_axil_wdata,
  output logic [STRB_WIDTH-1:0]       m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [RESP_W-1:0]           m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
  output logic [PROT_W-1:0]           m_axil_arprot,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
  input  logic [RESP_W-1:0]           m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready,
  // status
  output logic [$clog2(NUM_M)-1:0]    grant_idx,
  output logic [1:0]                  op
);

  localparam int unsigned IDX_W = $clog2(NUM_M);

  state_t           state;
  op_t              op_q;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic             aw_done;
  logic             w_done;

  logic             pick_any;
  logic [NUM_M-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_wr;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req        (s_axil_awvalid | s_axil_arvalid),
    .last_grant (last_grant),
    .any        (pick_any),
    .onehot     (pick_onehot),
    .idx        (pick_idx)
  );

  // a master offering both AW and AR is served as a write first
  assign pick_wr = |(s_axil_awvalid & pick_onehot);

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;
  assign b_hs  = m_axil_bvalid  & m_axil_bready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid  & m_axil_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_M - 1);
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick_idx;
            last_grant <= pick_idx;
            if (pick_wr) begin
              state <= WR;
              op_q  <= OP_WR;
            end else begin
              state <= RD;
              op_q  <= OP_RD;
            end
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WB;
        end
        WB: begin
          if (b_hs) begin
            state   <= IDLE;
            op_q    <= OP_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        RD: begin
          if (ar_hs) state <= RR;
        end
        RR: begin
          if (r_hs) begin
            state <= IDLE;
            op_q  <= OP_IDLE;
          end
        end
        default: begin
          state <= IDLE;
          op_q  <= OP_IDLE;
        end
      endcase
    end
  end

  // handshake signals only reach the granted master, and only in the phase that owns them
  always_comb begin
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    case (state)
      WR: begin
        m_axil_awvalid        = s_axil_awvalid[grant] & ~aw_done;
        s_axil_awready[grant] = m_axil_awready & ~aw_done;
        m_axil_wvalid         = s_axil_wvalid[grant] & ~w_done;
        s_axil_wready[grant]  = m_axil_wready & ~w_done;
      end
      WB: begin
        m_axil_bready        = s_axil_bready[grant];
        s_axil_bvalid[grant] = m_axil_bvalid;
      end
      RD: begin
        m_axil_arvalid        = s_axil_arvalid[grant];
        s_axil_arready[grant] = m_axil_arready;
      end
      RR: begin
        m_axil_rready        = s_axil_rready[grant];
        s_axil_rvalid[grant] = m_axil_rvalid;
      end
      default: ;
    endcase
  end

  assign m_axil_awaddr = s_axil_awaddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_awprot = s_axil_awprot[grant*PROT_W +: PROT_W];
  assign m_axil_wdata  = s_axil_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_axil_wstrb  = s_axil_wstrb[grant*STRB_WIDTH +: STRB_WIDTH];
  assign m_axil_araddr = s_axil_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_arprot = s_axil_arprot[grant*PROT_W +: PROT_W];

  assign s_axil_bresp = m_axil_bresp;
  assign s_axil_rdata = m_axil_rdata;
  assign s_axil_rresp = m_axil_rresp;

  assign grant_idx = grant;
  assign op        = op_q;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Scoreboard bench for axil_rr_arbiter: two masters, a simple slave model, and a monitor that
// checks every completed response against expectations pushed in predicted grant order.
module tb_axil_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] s_axil_awaddr, s_axil_araddr, s_axil_wdata;
  logic [5:0]  s_axil_awprot, s_axil_arprot;
  logic [7:0]  s_axil_wstrb;
  logic [1:0]  s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp, s_axil_bvalid, s_axil_bready;
  logic [1:0]  s_axil_arvalid, s_axil_arready, s_axil_rresp, s_axil_rvalid, s_axil_rready;
  logic [31:0] s_axil_rdata;
  logic [31:0] m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic        grant_idx;
  logic [1:0]  op;

  axil_rr_arbiter #(.NUM_M(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .grant_idx(grant_idx), .op(op)
  );

  // channel: 0 = AW, 1 = W, 2 = AR; delay counts idle cycles before valid rises
  typedef struct packed {
    int unsigned ch;
    int unsigned m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int unsigned delay;
  } item_t;

  typedef struct packed {
    int unsigned m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  item_t stim_q[$];
  exp_t  exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // master driver state
  bit          aw_act[2], w_act[2], ar_act[2];
  logic [31:0] aw_addr_d[2], w_data_d[2], ar_addr_d[2];
  logic [3:0]  w_strb_d[2];
  logic [1:0]  bready_mask = 2'b11;
  // handshakes sampled mid-cycle; they complete at the following rising edge
  logic [1:0]  aw_hs, w_hs, ar_hs;
  logic        m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
  logic [31:0] araddr_s;
  // slave model state
  bit          got_aw, got_w;
  int unsigned aw_stall = 0;
  logic [1:0]  slave_bresp = 2'b00;
  bit          aw_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic push_stim(input int unsigned ch, input int unsigned m, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int unsigned dly);
    item_t it;
    it.ch = ch; it.m = m; it.addr = addr; it.data = data; it.strb = strb; it.delay = dly;
    stim_q.push_back(it);
  endtask

  task automatic push_exp(input int unsigned m, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = addr; e.data = data; e.strb = strb; e.resp = resp;
    exp_q.push_back(e);
  endtask

  task automatic pull(input int unsigned ch, input int unsigned m, output bit got, output item_t it);
    got = 1'b0;
    it  = '0;
    for (int unsigned i = 0; i < stim_q.size(); i++) begin
      if (stim_q[i].ch == ch && stim_q[i].m == m) begin
        if (stim_q[i].delay == 0) begin
          it  = stim_q[i];
          got = 1'b1;
          stim_q.delete(i);
        end else begin
          stim_q[i].delay = stim_q[i].delay - 1;
        end
        return;
      end
    end
  endtask

  task automatic sample();
    aw_hs    = s_axil_awvalid & s_axil_awready;
    w_hs     = s_axil_wvalid & s_axil_wready;
    ar_hs    = s_axil_arvalid & s_axil_arready;
    m_aw_hs  = m_axil_awvalid & m_axil_awready;
    m_w_hs   = m_axil_wvalid & m_axil_wready;
    m_b_hs   = m_axil_bvalid & m_axil_bready;
    m_ar_hs  = m_axil_arvalid & m_axil_arready;
    m_r_hs   = m_axil_rvalid & m_axil_rready;
    araddr_s = m_axil_araddr;
  endtask

  task automatic update();
    item_t it;
    bit    got;
    for (int unsigned m = 0; m < 2; m++) begin
      if (aw_act[m] && aw_hs[m]) aw_act[m] = 1'b0;
      if (w_act[m] && w_hs[m])   w_act[m]  = 1'b0;
      if (ar_act[m] && ar_hs[m]) ar_act[m] = 1'b0;
      if (!aw_act[m]) begin
        pull(0, m, got, it);
        if (got) begin aw_act[m] = 1'b1; aw_addr_d[m] = it.addr; end
      end
      if (!w_act[m]) begin
        pull(1, m, got, it);
        if (got) begin w_act[m] = 1'b1; w_data_d[m] = it.data; w_strb_d[m] = it.strb; end
      end
      if (!ar_act[m]) begin
        pull(2, m, got, it);
        if (got) begin ar_act[m] = 1'b1; ar_addr_d[m] = it.addr; end
      end
    end
    s_axil_awvalid = {aw_act[1], aw_act[0]};
    s_axil_awaddr  = {aw_addr_d[1], aw_addr_d[0]};
    s_axil_awprot  = {3'd2, 3'd1};
    s_axil_wvalid  = {w_act[1], w_act[0]};
    s_axil_wdata   = {w_data_d[1], w_data_d[0]};
    s_axil_wstrb   = {w_strb_d[1], w_strb_d[0]};
    s_axil_arvalid = {ar_act[1], ar_act[0]};
    s_axil_araddr  = {ar_addr_d[1], ar_addr_d[0]};
    s_axil_arprot  = {3'd2, 3'd1};
    s_axil_bready  = bready_mask;
    s_axil_rready  = 2'b11;
    // slave model: B follows both AW and W; R data is A5A5A5A5 xor the read address
    if (rst) begin
      m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
    end else begin
      if (m_b_hs)  m_axil_bvalid = 1'b0;
      if (m_aw_hs) got_aw = 1'b1;
      if (m_w_hs)  got_w  = 1'b1;
      if (got_aw && got_w && !m_axil_bvalid) begin
        m_axil_bvalid = 1'b1; m_axil_bresp = slave_bresp; got_aw = 1'b0; got_w = 1'b0;
      end
      if (m_r_hs) m_axil_rvalid = 1'b0;
      if (m_ar_hs) begin
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'hA5A5A5A5 ^ araddr_s; m_axil_rresp = 2'b00;
      end
    end
    m_axil_awready = (aw_stall == 0);
    if (aw_stall > 0) aw_stall = aw_stall - 1;
    m_axil_wready  = 1'b1;
    m_axil_arready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update();
    @(negedge clk);
    sample();
  endtask

  task automatic run(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_all_responses"}, 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
  endtask

  // monitor: capture downstream payloads, score every upstream response
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [2:0]  cap_awprot, cap_arprot;
  logic [3:0]  cap_wstrb;

  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  bv, rv;
    if (!rst) begin
      if (m_axil_awvalid && m_axil_awready) begin cap_awaddr = m_axil_awaddr; cap_awprot = m_axil_awprot; end
      if (m_axil_wvalid && m_axil_wready)   begin cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb; end
      if (m_axil_arvalid && m_axil_arready) begin cap_araddr = m_axil_araddr; cap_arprot = m_axil_arprot; end
      for (int unsigned m = 0; m < 2; m++) begin
        bv = (s_axil_bvalid & s_axil_bready) >> m;
        rv = (s_axil_rvalid & s_axil_rready) >> m;
        if (bv[0] || rv[0]) begin
          chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_master", 64'(m), 64'(e.m));
            chk("resp_is_write", 64'(bv[0]), 64'(e.wr));
            chk("resp_grant_idx", 64'(grant_idx), 64'(e.m));
            if (bv[0]) begin
              chk("b_awaddr", 64'(cap_awaddr), 64'(e.addr));
              chk("b_awprot", 64'(cap_awprot), 64'(e.m + 1));
              chk("b_wdata", 64'(cap_wdata), 64'(e.data));
              chk("b_wstrb", 64'(cap_wstrb), 64'(e.strb));
              chk("b_bresp", 64'(s_axil_bresp), 64'(e.resp));
              chk("b_onehot", 64'(s_axil_bvalid), 64'd1 << e.m);
              chk("b_op", 64'(op), 64'd1);
            end else begin
              chk("r_araddr", 64'(cap_araddr), 64'(e.addr));
              chk("r_arprot", 64'(cap_arprot), 64'(e.m + 1));
              chk("r_rdata", 64'(s_axil_rdata), 64'(e.data));
              chk("r_rresp", 64'(s_axil_rresp), 64'(e.resp));
              chk("r_onehot", 64'(s_axil_rvalid), 64'd1 << e.m);
              chk("r_op", 64'(op), 64'd2);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    // 1: reset with every valid/ready input high
    rst = 1'b1;
    s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11; s_axil_arvalid = 2'b11;
    s_axil_bready = 2'b11; s_axil_rready = 2'b11;
    s_axil_awaddr = '1; s_axil_araddr = '1; s_axil_wdata = '1; s_axil_wstrb = '1;
    s_axil_awprot = '0; s_axil_arprot = '0;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
    m_axil_bvalid = 1'b1; m_axil_rvalid = 1'b1; m_axil_bresp = 2'b11; m_axil_rresp = 2'b11;
    m_axil_rdata = '1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'd0);
      chk("rst_s_valid", 64'({s_axil_bvalid, s_axil_rvalid}), 64'd0);
      chk("rst_m_valid", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 64'd0);
      chk("rst_m_ready", 64'({m_axil_bready, m_axil_rready}), 64'd0);
      chk("rst_op", 64'(op), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    end
    sample();
    update();
    rst = 1'b0;

    // 2: single write from M0
    slave_bresp = 2'b00;
    push_stim(0, 0, 32'h10, 32'h0, 4'h0, 0);
    push_stim(1, 0, 32'h0, 32'hDEADBEEF, 4'hF, 0);
    push_exp(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    run("single_write", 40);

    // 3: M1 W early, AW three cycles later, downstream AW stalled so W lands first
    slave_bresp = 2'b10;
    aw_stall    = 8;
    aw_seen     = 1'b0;
    push_stim(1, 1, 32'h0, 32'h12345678, 4'h3, 0);
    push_stim(0, 1, 32'h24, 32'h0, 4'h0, 3);
    push_exp(1, 1'b1, 32'h24, 32'h12345678, 4'h3, 2'b10);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
      if (n <= 4) begin
        chk("w_only_no_grant_wready", 64'(s_axil_wready), 64'd0);
        chk("w_only_no_grant_op", 64'(op), 64'd0);
      end
      if (!aw_seen) chk("wb_before_aw", 64'(m_axil_bready), 64'd0);
      if (m_aw_hs) aw_seen = 1'b1;
    end
    chk("w_before_aw_all_responses", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();

    // 4: both masters read back to back; grants alternate starting at M0
    slave_bresp = 2'b00;
    push_stim(2, 0, 32'h100, 32'h0, 4'h0, 0);
    push_stim(2, 0, 32'h104, 32'h0, 4'h0, 0);
    push_stim(2, 1, 32'h200, 32'h0, 4'h0, 0);
    push_stim(2, 1, 32'h204, 32'h0, 4'h0, 0);
    push_exp(0, 1'b0, 32'h100, 32'hA5A5A4A5, 4'h0, 2'b00);
    push_exp(1, 1'b0, 32'h200, 32'hA5A5A7A5, 4'h0, 2'b00);
    push_exp(0, 1'b0, 32'h104, 32'hA5A5A4A1, 4'h0, 2'b00);
    push_exp(1, 1'b0, 32'h204, 32'hA5A5A7A1, 4'h0, 2'b00);
    run("alternating_reads", 80);

    // 5: M0 offers AW+AR together; write first, then M1's read, then M0's read
    push_stim(0, 0, 32'h50, 32'h0, 4'h0, 0);
    push_stim(1, 0, 32'h0, 32'hCAFEF00D, 4'hF, 0);
    push_stim(2, 0, 32'h60, 32'h0, 4'h0, 0);
    push_stim(2, 1, 32'h70, 32'h0, 4'h0, 1);
    push_exp(0, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 2'b00);
    push_exp(1, 1'b0, 32'h70, 32'hA5A5A5D5, 4'h0, 2'b00);
    push_exp(0, 1'b0, 32'h60, 32'hA5A5A5C5, 4'h0, 2'b00);
    run("write_before_read", 80);

    // 6: reset while a B response is waiting on M0
    bready_mask = 2'b10;
    push_stim(0, 0, 32'h40, 32'h0, 4'h0, 0);
    push_stim(1, 0, 32'h0, 32'h0BADF00D, 4'hF, 0);
    n = 0;
    while (s_axil_bvalid[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("abort_reached_wb", 64'(s_axil_bvalid), 64'd1);
    rst = 1'b1;
    tick();
    chk("abort_bvalid", 64'(s_axil_bvalid), 64'd0);
    chk("abort_bready", 64'(m_axil_bready), 64'd0);
    chk("abort_op", 64'(op), 64'd0);
    chk("abort_grant_idx", 64'(grant_idx), 64'd0);
    rst = 1'b0;
    bready_mask = 2'b11;
    push_stim(2, 0, 32'h300, 32'h0, 4'h0, 0);
    push_stim(2, 1, 32'h304, 32'h0, 4'h0, 0);
    push_exp(0, 1'b0, 32'h300, 32'hA5A5A6A5, 4'h0, 2'b00);
    push_exp(1, 1'b0, 32'h304, 32'hA5A5A6A1, 4'h0, 2'b00);
    run("after_abort", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
